// File: rtl/mult32x32_host.sv
// rtl/mult32x32_host.sv - operand FIFO and start/busy sequencer driving one mult32x32
module mult32x32_host #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_busy,
  input  logic [63:0] mul_product,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_product,
  output logic        err_timeout,
  output logic [15:0] job_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [63:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, empty, push, pop;
  logic [TW-1:0]   tmo_cnt, tmo_cnt_nx;
  logic            start_nx, load, capture, timeout_hit, accept;
  logic [63:0]     head;

  // The head entry stays queued while its job is in flight; it is only
  // popped when the job completes or is abandoned, so in_ready reflects
  // the issued job as well as the waiting ones.
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem[rd_ptr];

  // FIFO storage; data needs no reset because count gates its use
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  // Next-state and control decode for the job sequencer
  always_comb begin
    state_nx    = state;
    tmo_cnt_nx  = tmo_cnt;
    start_nx    = 1'b0;
    load        = 1'b0;
    capture     = 1'b0;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !mul_busy) begin
          load       = 1'b1;
          start_nx   = 1'b1;
          tmo_cnt_nx = '0;
          state_nx   = ARM;
        end
      end
      ARM: begin
        // The cycle carrying the start pulse itself is not charged to the
        // timeout; the multiplier cannot have raised busy yet.
        if (mul_busy) begin
          state_nx = RUN;
        end else if (!mul_start) begin
          tmo_cnt_nx = tmo_cnt + 1'b1;
          if (tmo_cnt_nx == TW'(BUSY_TIMEOUT)) begin
            timeout_hit = 1'b1;
            pop         = 1'b1;
            state_nx    = IDLE;
          end
        end
      end
      RUN: begin
        if (!mul_busy) begin
          capture  = 1'b1;
          pop      = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          accept   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, operand registers, result holding and status counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      res_valid   <= 1'b0;
      res_product <= '0;
      err_timeout <= 1'b0;
      job_count   <= '0;
    end else begin
      state     <= state_nx;
      tmo_cnt   <= tmo_cnt_nx;
      mul_start <= start_nx;
      if (load) begin
        mul_a <= head[63:32];
        mul_b <= head[31:0];
      end
      if (capture) begin
        res_product <= mul_product;
        res_valid   <= 1'b1;
        job_count   <= job_count + 1'b1;
      end else if (accept) begin
        res_valid <= 1'b0;
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult32x32_host.sv
// tb/tb_mult32x32_host.sv - directed self-checking bench for mult32x32_host
module tb_mult32x32_host;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        mul_start;
  logic [31:0] mul_a, mul_b;
  logic        mul_busy;
  logic [63:0] mul_product;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_product;
  logic        err_timeout;
  logic [15:0] job_count;

  int checks = 0;
  int errors = 0;

  localparam int MUL_LAT = 3;
  logic        stub;
  int          lat_cnt;
  logic [63:0] prod_q;

  mult32x32_host #(.FIFO_DEPTH(4), .BUSY_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_busy(mul_busy), .mul_product(mul_product), .res_valid(res_valid),
    .res_ready(res_ready), .res_product(res_product), .err_timeout(err_timeout),
    .job_count(job_count)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: busy for MUL_LAT cycles after start; stub mode never responds
  assign mul_product = prod_q;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_busy <= 1'b0;
      lat_cnt  <= 0;
      prod_q   <= '0;
    end else if (mul_start && !stub) begin
      prod_q   <= {32'd0, mul_a} * {32'd0, mul_b};
      mul_busy <= 1'b1;
      lat_cnt  <= MUL_LAT;
    end else if (lat_cnt > 1) begin
      lat_cnt <= lat_cnt - 1;
    end else if (lat_cnt == 1) begin
      lat_cnt  <= 0;
      mul_busy <= 1'b0;
    end
  end

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk1("push_wait", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk1(tag, res_valid, 1'b1);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!mul_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk1(tag, mul_start, 1'b1);
  endtask

  task automatic accept_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] held;
    logic [63:0] got [4];
    int starts, bad, k, n;
    logic seen;

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0; stub = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk1 ("rst_in_ready", in_ready, 1'b1);
    chk1 ("rst_mul_start", mul_start, 1'b0);
    chk64("rst_mul_a", 64'(mul_a), 64'd0);
    chk64("rst_mul_b", 64'(mul_b), 64'd0);
    chk1 ("rst_res_valid", res_valid, 1'b0);
    chk64("rst_res_product", res_product, 64'd0);
    chk1 ("rst_err_timeout", err_timeout, 1'b0);
    chk64("rst_job_count", 64'(job_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single job: one start, stable operands, correct product
    push(32'd209728609, 32'd212015051);
    wait_start("single_start_wait");
    starts = 0; bad = 0;
    while (!res_valid && starts < 50) begin
      if (mul_start) starts++;
      if (mul_a !== 32'd209728609 || mul_b !== 32'd212015051) bad++;
      @(negedge clk);
    end
    chk64("single_start_pulses", 64'(starts), 64'd1);
    chk64("single_operands_stable", 64'(bad), 64'd0);
    chk1 ("single_res_valid", res_valid, 1'b1);
    chk64("single_product", res_product, 64'd44465621733294059);
    chk64("single_job_count", 64'(job_count), 64'd1);
    accept_res();
    chk1 ("single_res_cleared", res_valid, 1'b0);

    // Extremes, in order
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(32'h0000_0000, 32'h1234_5678);
    wait_res("ext1_wait");
    chk64("ext_max_product", res_product, 64'hFFFF_FFFE_0000_0001);
    accept_res();
    wait_res("ext2_wait");
    chk64("ext_zero_product", res_product, 64'd0);
    accept_res();
    chk64("ext_job_count", 64'(job_count), 64'd3);

    // FIFO fill with results held back
    push(32'd3, 32'd5);
    push(32'd7, 32'd11);
    push(32'd13, 32'd17);
    push(32'd19, 32'd23);
    chk1("fill_in_ready_low", in_ready, 1'b0);
    push(32'd29, 32'd31);
    wait_res("fill_first_wait");
    chk64("fill_first_product", res_product, 64'd15);

    // Backpressure: result held, no new start
    held = res_product;
    bad = 0; starts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_product !== held || !res_valid) bad++;
      if (mul_start) starts++;
    end
    chk64("bp_product_stable", 64'(bad), 64'd0);
    chk64("bp_no_start", 64'(starts), 64'd0);
    res_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (mul_start) seen = 1'b1;
    end
    chk1("bp_restart_within_2", seen, 1'b1);

    k = 0; n = 0;
    while (k < 4 && n < 200) begin
      if (res_valid) begin
        got[k] = res_product;
        k++;
      end
      @(negedge clk);
      n++;
    end
    chk64("fill_result_count", 64'(k), 64'd4);
    chk64("fill_product_2", got[0], 64'd77);
    chk64("fill_product_3", got[1], 64'd221);
    chk64("fill_product_4", got[2], 64'd437);
    chk64("fill_product_5", got[3], 64'd899);
    chk64("fill_job_count", 64'(job_count), 64'd8);

    // Busy timeout with a non-responding multiplier
    stub = 1'b1;
    push(32'd2, 32'd3);
    wait_start("tmo_start_wait");
    bad = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (res_valid) bad++;
      if (i == 8) chk1("tmo_err_not_early", err_timeout, 1'b0);
      if (i == 9) chk1("tmo_err_set", err_timeout, 1'b1);
    end
    starts = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid) bad++;
      if (mul_start) starts++;
    end
    chk64("tmo_no_result", 64'(bad), 64'd0);
    chk64("tmo_fifo_empty_no_start", 64'(starts), 64'd0);
    chk1 ("tmo_in_ready", in_ready, 1'b1);
    chk1 ("tmo_err_sticky", err_timeout, 1'b1);
    chk64("tmo_job_count", 64'(job_count), 64'd8);
    stub = 1'b0;

    // Asynchronous reset during RUN with pairs queued
    push(32'd5, 32'd6);
    push(32'd7, 32'd8);
    push(32'd9, 32'd10);
    n = 0;
    while (!mul_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("arst_reached_run", mul_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1 ("arst_in_ready", in_ready, 1'b1);
    chk1 ("arst_mul_start", mul_start, 1'b0);
    chk64("arst_mul_a", 64'(mul_a), 64'd0);
    chk64("arst_mul_b", 64'(mul_b), 64'd0);
    chk1 ("arst_res_valid", res_valid, 1'b0);
    chk64("arst_res_product", res_product, 64'd0);
    chk1 ("arst_err_timeout", err_timeout, 1'b0);
    chk64("arst_job_count", 64'(job_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push(32'd4, 32'd4);
    wait_res("arst_new_wait");
    chk64("arst_new_product", res_product, 64'd16);
    chk64("arst_new_job_count", 64'(job_count), 64'd1);
    accept_res();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid || mul_start) bad++;
    end
    chk64("arst_queue_dropped", 64'(bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1);
  end

endmodule
